md5_cmd_sequencer: RTL and testbench

MD5_CMD_SEQUENCER -- requirements
Module: md5_cmd_sequencer

---
 rtl/md5_cmd_pkg.sv | 61 ++++++
 rtl/md5_cmd_sequencer_if.sv | 32 +++
 rtl/md5_word_strobe.sv | 80 ++++++++
 rtl/md5_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_md5_cmd_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md5_cmd_pkg.sv
// md5_cmd_pkg
// Shared definitions for the MD5 brute-forcer command sequencer: the command
// word constants, the program length, the FSM state type, the word-strobe
// phase type and two small helpers (program word lookup, saturating increment).
package md5_cmd_pkg;

  localparam logic [31:0] ResetGenerator = 32'h5230_0000;
  localparam logic [31:0] StartGenerator = 32'h5230_0001;
  localparam logic [31:0] SetExpectedA   = 32'h5230_1000;
  localparam logic [31:0] SetExpectedB   = 32'h5230_1001;
  localparam logic [31:0] SetExpectedC   = 32'h5230_1002;
  localparam logic [31:0] SetExpectedD   = 32'h5230_1003;
  localparam logic [31:0] SetRange       = 32'h5230_2000;
  localparam logic [31:0] GetCountLow    = 32'h5230_3000;
  localparam logic [31:0] GetCountHigh   = 32'h5230_3001;

  localparam int unsigned ProgLen = 12;

  typedef enum logic [2:0] {
    IDLE,
    STROBE_HI,
    STROBE_LO,
    WAIT_RESP,
    FINISH
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HI,
    PH_LO
  } strobe_phase_e;

  // Word idx of the programming sequence, built from the snapshotted target.
  function automatic logic [31:0] program_word(input logic [31:0]  idx,
                                               input logic [127:0] hash,
                                               input logic [7:0]   rmin,
                                               input logic [7:0]   rmax);
    logic [31:0] w;
    case (idx)
      32'd0:   w = ResetGenerator;
      32'd1:   w = SetExpectedA;
      32'd2:   w = hash[127:96];
      32'd3:   w = SetExpectedB;
      32'd4:   w = hash[95:64];
      32'd5:   w = SetExpectedC;
      32'd6:   w = hash[63:32];
      32'd7:   w = SetExpectedD;
      32'd8:   w = hash[31:0];
      32'd9:   w = SetRange;
      32'd10:  w = {16'h0000, rmax, rmin};
      32'd11:  w = StartGenerator;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/md5_cmd_sequencer_if.sv
// md5_cmd_sequencer_if
// Groups the request side (start/poll with the target and range), the
// brute-forcer side (cmd_data/cmd_strobe out, resp_data/matched in) and the
// status outputs of the sequencer.
//   slave  : view of the sequencer itself
//   master : view of whoever drives requests and models the brute-forcer
interface md5_cmd_sequencer_if;
  logic         start;
  logic [127:0] target_hash;
  logic [7:0]   range_min;
  logic [7:0]   range_max;
  logic         poll;
  logic [31:0]  resp_data;
  logic         matched;
  logic [31:0]  cmd_data;
  logic         cmd_strobe;
  logic         busy;
  logic         done;
  logic [63:0]  count;
  logic         count_valid;
  logic         match_seen;

  modport slave (
    input  start, target_hash, range_min, range_max, poll, resp_data, matched,
    output cmd_data, cmd_strobe, busy, done, count, count_valid, match_seen
  );

  modport master (
    output start, target_hash, range_min, range_max, poll, resp_data, matched,
    input  cmd_data, cmd_strobe, busy, done, count, count_valid, match_seen
  );
endinterface

// File: rtl/md5_word_strobe.sv
// md5_word_strobe
// Timing for one command word: after a load pulse the strobe is high for
// STROBE_CYCLES cycles, then low for GAP_CYCLES cycles.
//   clk, reset : clock, synchronous active-low reset
//   load       : start a word at the next edge (restarts any word in flight)
//   strobe     : registered word-valid strobe
//   in_gap     : high during the low (gap) phase
//   word_done  : high in the last gap cycle, so a load issued in response
//                raises the next strobe with no dead cycle
module md5_word_strobe
  import md5_cmd_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic strobe,
  output logic in_gap,
  output logic word_done
);

  strobe_phase_e phase_q, phase_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  assign word_done = (phase_q == PH_LO) && (cnt_q == 32'(GAP_CYCLES - 1));
  assign in_gap    = (phase_q == PH_LO);
  assign strobe    = strobe_q;

  always_comb begin
    // NOTE: every _d signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    if (load) begin
      phase_d  = PH_HI;
      cnt_d    = '0;
      strobe_d = 1'b1;
    end else begin
      case (phase_q)
        PH_HI: begin
          if (cnt_q == 32'(STROBE_CYCLES - 1)) begin
            phase_d  = PH_LO;
            cnt_d    = '0;
            strobe_d = 1'b0;
          end else begin
            cnt_d = sat_inc32(cnt_q);
          end
        end
        PH_LO: begin
          if (word_done) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc32(cnt_q);
          end
        end
        default: begin
          phase_d = PH_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments; the reset is synchronous, so it only acts at a clock edge.
    if (!reset) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: rtl/md5_cmd_sequencer.sv
// md5_cmd_sequencer
// Drives the MD5 brute-forcer command port. A start request snapshots the
// target digest and character range and sends the 12-word programming
// sequence, pulsing done at the end. With MD5_CMD_POLL_EN defined, a poll
// request reads the 64-bit candidate count as two 32-bit responses and
// publishes both halves together with a count_valid pulse.
//   clk, reset : clock, synchronous active-low reset
//   bus        : md5_cmd_sequencer_if.slave (requests, command port, status)
// Optional feature macro: MD5_CMD_POLL_EN (count polling).
module md5_cmd_sequencer
  import md5_cmd_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
`ifdef MD5_CMD_POLL_EN
  ,
  parameter int unsigned RESP_WAIT     = 4
`endif
) (
  input logic                clk,
  input logic                reset,
  md5_cmd_sequencer_if.slave bus
);

  seq_state_e   state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         launch_q, launch_d;
  logic         poll_mode_q, poll_mode_d;
  logic         match_seen_q, match_seen_d;
  logic [31:0]  cmd_data_q, cmd_data_d;
  logic [31:0]  word_cnt_q, word_cnt_d;
  logic [127:0] hash_q, hash_d;
  logic [7:0]   rmin_q, rmin_d;
  logic [7:0]   rmax_q, rmax_d;

  logic         poll_req, wait_done, load;
  logic         ws_strobe, ws_in_gap, ws_word_done;
  logic [31:0]  next_word;

`ifdef MD5_CMD_POLL_EN
  logic [31:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]  count_lo_q, count_lo_d;
  logic [63:0]  count_q, count_d;
  logic         count_valid_q, count_valid_d;

  assign poll_req  = bus.poll;
  assign wait_done = (state_q == WAIT_RESP) && (wait_cnt_q == 32'(RESP_WAIT - 1));
`else
  logic         unused_poll_inputs;

  assign unused_poll_inputs = ^{bus.poll, bus.resp_data};
  assign poll_req  = 1'b0;
  assign wait_done = 1'b0;
`endif

  // A word is loaded one cycle after acceptance, back-to-back after each
  // program word's gap, and after the first poll response has been sampled.
  assign load = launch_q
              | ((state_q == STROBE_LO) && ws_word_done && !poll_mode_q &&
                 (word_cnt_q < 32'(ProgLen)))
              | (wait_done && (word_cnt_q == 32'd1));

  assign next_word = poll_mode_q ? ((word_cnt_q == 32'd0) ? GetCountLow : GetCountHigh)
                                 : program_word(word_cnt_q, hash_q, rmin_q, rmax_q);

  md5_word_strobe #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES)
  ) u_word_strobe (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .strobe    (ws_strobe),
    .in_gap    (ws_in_gap),
    .word_done (ws_word_done)
  );

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    launch_d     = 1'b0;
    poll_mode_d  = poll_mode_q;
    match_seen_d = match_seen_q;
    cmd_data_d   = cmd_data_q;
    word_cnt_d   = word_cnt_q;
    hash_d       = hash_q;
    rmin_d       = rmin_q;
    rmax_d       = rmax_q;
`ifdef MD5_CMD_POLL_EN
    wait_cnt_d    = wait_cnt_q;
    count_lo_d    = count_lo_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
`endif

    case (state_q)
      // FINISH is the one-cycle tail after busy falls; it accepts requests
      // exactly like IDLE so a back-to-back request is not lost.
      IDLE, FINISH: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d      = STROBE_HI;
          busy_d       = 1'b1;
          launch_d     = 1'b1;
          poll_mode_d  = 1'b0;
          word_cnt_d   = '0;
          hash_d       = bus.target_hash;
          rmin_d       = bus.range_min;
          rmax_d       = bus.range_max;
          match_seen_d = 1'b0;
        end else if (poll_req) begin
          state_d     = STROBE_HI;
          busy_d      = 1'b1;
          launch_d    = 1'b1;
          poll_mode_d = 1'b1;
          word_cnt_d  = '0;
        end
      end
      STROBE_HI: begin
        if (ws_in_gap) state_d = STROBE_LO;
      end
      STROBE_LO: begin
        if (ws_word_done) begin
          if (poll_mode_q) begin
            state_d = WAIT_RESP;
`ifdef MD5_CMD_POLL_EN
            wait_cnt_d = '0;
`endif
          end else if (load) begin
            state_d = STROBE_HI;
          end else begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      WAIT_RESP: begin
`ifdef MD5_CMD_POLL_EN
        if (wait_done) begin
          if (word_cnt_q == 32'd1) begin
            count_lo_d = bus.resp_data;
            state_d    = STROBE_HI;
          end else begin
            count_d       = {bus.resp_data, count_lo_q};
            count_valid_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = FINISH;
          end
        end else begin
          wait_cnt_d = sat_inc32(wait_cnt_q);
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    // A match in the acceptance cycle still counts as seen.
    if (bus.matched) match_seen_d = 1'b1;

    if (load) begin
      cmd_data_d = next_word;
      word_cnt_d = sat_inc32(word_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      launch_q     <= 1'b0;
      poll_mode_q  <= 1'b0;
      match_seen_q <= 1'b0;
      cmd_data_q   <= '0;
      word_cnt_q   <= '0;
      hash_q       <= '0;
      rmin_q       <= '0;
      rmax_q       <= '0;
`ifdef MD5_CMD_POLL_EN
      wait_cnt_q    <= '0;
      count_lo_q    <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      launch_q     <= launch_d;
      poll_mode_q  <= poll_mode_d;
      match_seen_q <= match_seen_d;
      cmd_data_q   <= cmd_data_d;
      word_cnt_q   <= word_cnt_d;
      hash_q       <= hash_d;
      rmin_q       <= rmin_d;
      rmax_q       <= rmax_d;
`ifdef MD5_CMD_POLL_EN
      wait_cnt_q    <= wait_cnt_d;
      count_lo_q    <= count_lo_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
`endif
    end
  end

  assign bus.cmd_data   = cmd_data_q;
  assign bus.cmd_strobe = ws_strobe;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.match_seen = match_seen_q;
`ifdef MD5_CMD_POLL_EN
  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
`else
  assign bus.count       = 64'd0;
  assign bus.count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_md5_cmd_sequencer.sv
// tb_md5_cmd_sequencer
// Scoreboard bench: request tasks push the expected command words, done and
// count events (with the cycle each must appear in) into a queue; a monitor
// pops and compares whenever the DUT shows a strobe rise, done or count_valid.
// A small responder plays the brute-forcer for the count reads.
module tb_md5_cmd_sequencer;

  localparam int S        = 2;
  localparam int G        = 2;
  localparam int RW       = 4;
  localparam int WORD_T   = S + G;
  localparam int NWORDS   = 12;
  localparam int PROG_LAT = 1 + NWORDS * WORD_T;
  localparam int POLL_LAT = 1 + 2 * WORD_T + 2 * RW;

  localparam int EV_WORD  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_COUNT = 2;

  typedef struct {
    int          kind;
    logic [63:0] data;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md5_cmd_sequencer_if bus ();

  md5_cmd_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  ev_t         exp_q[$];
  bit          model_match = 1'b0;
  logic [63:0] model_count = 64'd0;
  logic [31:0] resp_lo = 32'd0;
  logic [31:0] resp_hi = 32'd0;
  int          free_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic observe(input int kind, input logic [63:0] act);
    ev_t e;
    if (exp_q.size() == 0) begin
      check(1'b0, $sformatf("unexpected_event_kind%0d", kind), act, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.kind == kind && e.data == act,
            $sformatf("event_kind%0d_exp_kind%0d", kind, e.kind), act, e.data);
      check(e.cyc == cyc, $sformatf("event_kind%0d_cycle", kind),
            64'(cyc), 64'(e.cyc));
    end
  endtask

  initial begin
    bit strobe_prev;
    strobe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cmd_strobe === 1'b1 && !strobe_prev) observe(EV_WORD, 64'(bus.cmd_data));
      if (bus.done === 1'b1) observe(EV_DONE, 64'd0);
      if (bus.count_valid === 1'b1) observe(EV_COUNT, bus.count);
      strobe_prev = (bus.cmd_strobe === 1'b1);
    end
  end

  // Brute-forcer stand-in: answers the two count reads.
  initial forever begin
    @(negedge clk);
    if (bus.cmd_strobe === 1'b1) begin
      if (bus.cmd_data == 32'h5230_3000) bus.resp_data = resp_lo;
      else if (bus.cmd_data == 32'h5230_3001) bus.resp_data = resp_hi;
    end
  end

  // ---------------- reference model ----------------
  function automatic void push_ev(input int kind, input logic [63:0] data, input int c);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_program(input int a, input logic [127:0] h,
                                       input logic [7:0] mn, input logic [7:0] mx);
    logic [31:0] w [NWORDS];
    w = '{32'h5230_0000, 32'h5230_1000, h[127:96], 32'h5230_1001, h[95:64],
          32'h5230_1002, h[63:32], 32'h5230_1003, h[31:0], 32'h5230_2000,
          {16'h0000, mx, mn}, 32'h5230_0001};
    for (int j = 0; j < NWORDS; j++) push_ev(EV_WORD, 64'(w[j]), a + 1 + j * WORD_T);
    push_ev(EV_DONE, 64'd0, a + PROG_LAT);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [127:0] h, input logic [7:0] mn,
                          input logic [7:0] mx, input bit with_poll, output int a);
    bus.start       = 1'b1;
    bus.poll        = with_poll;
    bus.target_hash = h;
    bus.range_min   = mn;
    bus.range_max   = mx;
    @(posedge clk);
    #1;
    a = cyc;
    bus.start       = 1'b0;
    bus.poll        = 1'b0;
    bus.target_hash = {4{$urandom}};
    bus.range_min   = 8'($urandom);
    bus.range_max   = 8'($urandom);
    model_match = 1'b0;
    push_program(a, h, mn, mx);
    free_cyc = a + PROG_LAT;
    check(bus.busy == 1'b1, "busy_after_start", 64'(bus.busy), 64'd1);
    check(bus.match_seen == model_match, "match_seen_cleared_by_start",
          64'(bus.match_seen), 64'(model_match));
  endtask

`ifdef MD5_CMD_POLL_EN
  task automatic do_poll(input logic [31:0] lo, input logic [31:0] hi, output int a);
    resp_lo  = lo;
    resp_hi  = hi;
    bus.poll = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    bus.poll = 1'b0;
    push_ev(EV_WORD, 64'(32'h5230_3000), a + 1);
    push_ev(EV_WORD, 64'(32'h5230_3001), a + 1 + WORD_T + RW);
    push_ev(EV_COUNT, {hi, lo}, a + POLL_LAT);
    free_cyc = a + POLL_LAT;
    check(bus.busy == 1'b1, "busy_after_poll", 64'(bus.busy), 64'd1);
    // Neither half may show up early.
    wait_until(a + POLL_LAT - 2);
    check(bus.count == model_count, "count_held_mid_poll", bus.count, model_count);
    model_count = {hi, lo};
  endtask
`endif

  task automatic pulse_match();
    bus.matched = 1'b1;
    @(posedge clk);
    #1;
    bus.matched = 1'b0;
    model_match = 1'b1;
  endtask

  task automatic pulse_ignored_request();
    bus.start       = 1'b1;
    bus.poll        = 1'($urandom);
    bus.target_hash = {4{$urandom}};
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.poll  = 1'b0;
  endtask

  task automatic finish_seq(input string tag);
    wait_until(free_cyc);
    check(bus.busy == 1'b0, {tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    wait_until(free_cyc + 2);
    check(exp_q.size() == 0, {tag, "_scoreboard_drained"}, 64'(exp_q.size()), 64'd0);
    check(bus.match_seen == model_match, {tag, "_match_seen"},
          64'(bus.match_seen), 64'(model_match));
    check(bus.count == model_count, {tag, "_count"}, bus.count, model_count);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a;
    bus.start       = 1'b0;
    bus.poll        = 1'b0;
    bus.matched     = 1'b0;
    bus.resp_data   = 32'd0;
    bus.target_hash = 128'd0;
    bus.range_min   = 8'd0;
    bus.range_max   = 8'd0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(bus.cmd_data == 32'd0, "reset_cmd_data", 64'(bus.cmd_data), 64'd0);
    check(bus.cmd_strobe == 1'b0, "reset_cmd_strobe", 64'(bus.cmd_strobe), 64'd0);
    check(bus.busy == 1'b0, "reset_busy", 64'(bus.busy), 64'd0);
    check(bus.done == 1'b0, "reset_done", 64'(bus.done), 64'd0);
    check(bus.count == 64'd0, "reset_count", bus.count, 64'd0);
    check(bus.count_valid == 1'b0, "reset_count_valid", 64'(bus.count_valid), 64'd0);
    check(bus.match_seen == 1'b0, "reset_match_seen", 64'(bus.match_seen), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Known digest and range: words and done cycle come from the scoreboard.
    do_start(128'h0123456789ABCDEF_FEDCBA9876543210, 8'h61, 8'h7A, 1'b0, a);
    wait_until(a + PROG_LAT - 1);
    check(bus.busy == 1'b1, "busy_before_done", 64'(bus.busy), 64'd1);
    finish_seq("directed_program");

`ifdef MD5_CMD_POLL_EN
    do_poll(32'h0000_0005, 32'h0000_0001, a);
    finish_seq("directed_poll");
    check(bus.count == 64'h0000_0001_0000_0005, "directed_count",
          bus.count, 64'h0000_0001_0000_0005);
`endif

    // start and poll together: only the program runs; a start at cycle 10
    // is ignored; a mid-sequence match stays sticky.
    do_start(128'hDEADBEEF_00112233_44556677_8899AABB, 8'h30, 8'h39, 1'b1, a);
    wait_until(a + 4);
    pulse_match();
    wait_until(a + 9);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    finish_seq("start_poll_collision");

    // Randomised requests with ignored requests and match pulses in flight.
    for (int it = 0; it < 10; it++) begin
      int m;
      int k;
`ifdef MD5_CMD_POLL_EN
      if ($urandom_range(0, 2) == 0) begin
        do_poll($urandom, $urandom, a);
        finish_seq("random_poll");
        continue;
      end
`endif
      do_start({$urandom, $urandom, $urandom, $urandom}, 8'($urandom_range(32, 80)),
               8'($urandom_range(81, 126)), 1'($urandom), a);
      m = $urandom_range(2, 15);
      k = $urandom_range(18, 44);
      wait_until(a + m);
      if ($urandom_range(0, 1) == 1) pulse_match();
      wait_until(a + k);
      pulse_ignored_request();
      finish_seq("random_program");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset while word index 4 (the B digest word) has its strobe high.
    do_start(128'hCAFEF00D_12345678_9ABCDEF0_0FEDCBA9, 8'h41, 8'h5A, 1'b0, a);
    wait_until(a + 1 + 4 * WORD_T);
    reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_match = 1'b0;
    model_count = 64'd0;
    check(bus.cmd_strobe == 1'b0, "abort_cmd_strobe", 64'(bus.cmd_strobe), 64'd0);
    check(bus.busy == 1'b0, "abort_busy", 64'(bus.busy), 64'd0);
    check(bus.cmd_data == 32'd0, "abort_cmd_data", 64'(bus.cmd_data), 64'd0);
    reset = 1'b1;
    free_cyc = cyc + 60;
    finish_seq("after_abort");

`ifndef MD5_CMD_POLL_EN
    // Polling compiled out: a poll must do nothing at all.
    bus.poll = 1'b1;
    @(posedge clk);
    #1;
    bus.poll = 1'b0;
    check(bus.busy == 1'b0, "poll_disabled_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check(bus.cmd_strobe == 1'b0, "poll_disabled_strobe", 64'(bus.cmd_strobe), 64'd0);
    free_cyc = cyc + 20;
    finish_seq("poll_disabled");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
